lcd_ram_arbiter: RTL and testbench
==================================

// Module: lcd_ram_arbiter
// PURPOSE
//  Shares the single-port 64x64-bit frame RAM between a word writer (game/pattern logic)
//  and the LCD page reader (fetches 8-word pages for column transposition).
//  Sequences all RAM accesses, owns ram_we/ram_addr/ram_din, returns read data as
//  8-beat bursts. Read side has default priority; a starvation counter guarantees write progress.
// PARAMETERS
//  AW          6   RAM address width (64 words)
//  DW          64  RAM word width
//  BURST       8   words per read burst (page); power of two
//  STARVE_MAX  16  cycles a pending write may wait before it beats a read request
// PORTS
//  clk        in   1   clock
//  rst_n      in   1   reset, asynchronous, active-low
//  wr_req     in   1   write request; held until wr_ack
//  wr_addr    in   AW  write address, sampled at grant
//  wr_data    in   DW  write data, sampled at grant
//  wr_ack     out  1   one-cycle pulse in the cycle the write is performed
//  rd_req     in   1   page read request; sampled only in IDLE
//  rd_base    in   AW  page base; low log2(BURST) bits ignored (forced 0)
//  rd_grant   out  1   one-cycle pulse, first cycle of burst
//  rd_busy    out  1   high from grant through rd_last cycle
//  rd_valid   out  1   read data beat valid
//  rd_data    out  DW  read data (registered)
//  rd_last    out  1   high with the 8th beat
//  ram_we     out  1   RAM write enable
//  ram_addr   out  AW  RAM address (registered)
//  ram_din    out  DW  RAM write data (registered)
//  ram_dout   in   DW  RAM read data, valid one cycle after ram_addr
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, starve_cnt=0, burst counter=0. Mid-burst reset abandons
//   the burst: no further rd_valid, no rd_last; no write is performed or acked.
//  States: IDLE, WR, RD_BURST, RD_DRAIN.
//  IDLE arbitration (cycle 0): write wins if wr_req && (!rd_req || starve_cnt==STARVE_MAX);
//   else read wins if rd_req; else stay.
//  WR (1 cycle): ram_we=1, ram_addr/ram_din = values latched at grant, wr_ack=1; -> IDLE.
//   Back-to-back writes: one per 2 cycles. ram_we is 0 in every other state.
//  RD_BURST: rd_grant=1 in first cycle; ram_addr = base+0..BURST-1 in cycles 1..8 (3-bit
//   offset, never crosses page). -> RD_DRAIN after offset BURST-1.
//  RD_DRAIN: 2 cycles (cycles 9,10) to flush RAM + output register; -> IDLE at cycle 11.
//  Read data: ram_dout registered into rd_data; rd_valid cycles 3..10, beat k = word base+k;
//   rd_last with beat 7 (cycle 10); rd_busy cycles 1..10. rd_data holds last value otherwise.
//  starve_cnt: +1 each cycle wr_req=1 and state!=WR, saturates at STARVE_MAX; cleared in WR.
//  Coherency: a write acked before a burst grant is visible to that burst.
//  rd_req/wr_req changes outside IDLE ignored; requests are levels, not latched.
// TESTING
//  1 Reset: rst_n=0 mid-activity -> all outputs 0 same cycle; after release IDLE, no spurious ack.
//  2 Write wr_addr=5,wr_data=64'hA5A5.. -> cycle1 ram_we=1,ram_addr=5,ram_din=A5A5..,wr_ack=1.
//  3 Preload word i=i; rd_req,rd_base=8 -> rd_valid cycles 3..10 data 8..15, rd_last at 10.
//  4 rd_base=13 -> identical to base 8 (data 8..15); rd_base=56 -> 56..63, no wrap to 0.
//  5 rd_req & wr_req same cycle, starve_cnt=0 -> burst first, write acked cycle 12, new data
//    visible in a following burst.
//  6 rd_req and wr_req held high continuously -> write acked after starve_cnt hits 16,
//    then bursts resume; never two bursts while starve_cnt==16.

Source files
------------

// File: rtl/lcd_ram_arbiter.sv
// Arbitrates the single-port frame RAM between the word writer and the LCD page reader.
// Reads win by default; a saturating starvation counter lets a waiting write through.
//   state    | meaning
//   IDLE     | arbitration point, no RAM access
//   WR       | RAM write of the word latched at grant, wr_ack pulses
//   RD_BURST | one page address per cycle, base+0 .. base+BURST-1
//   RD_DRAIN | flush RAM latency and rd_data register
module lcd_ram_arbiter #(
    parameter int AW         = 6,
    parameter int DW         = 64,
    parameter int BURST      = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_base,
    output logic          rd_grant,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int OW = $clog2(BURST);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WR, RD_BURST, RD_DRAIN} state_t;

    state_t           state, state_nx;
    logic [OW-1:0]    beat_cnt;
    logic [AW-OW-1:0] page;
    logic [SW-1:0]    starve_cnt;
    logic             starved;
    logic             wr_win, rd_win;
    logic             dout_v, dout_last;
    logic             rd_base_unused;

    assign rd_base_unused = ^rd_base[OW-1:0];
    assign starved        = (starve_cnt == SW'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        wr_win   = 1'b0;
        rd_win   = 1'b0;
        case (state)
            IDLE: begin
                if (wr_req && (!rd_req || starved)) begin
                    wr_win   = 1'b1;
                    state_nx = WR;
                end else if (rd_req) begin
                    rd_win   = 1'b1;
                    state_nx = RD_BURST;
                end
            end
            WR:       state_nx = IDLE;
            RD_BURST: if (beat_cnt == OW'(BURST - 1)) state_nx = RD_DRAIN;
            RD_DRAIN: if (beat_cnt == OW'(1)) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign wr_ack   = (state == WR);
    assign ram_we   = (state == WR);
    assign rd_grant = (state == RD_BURST) && (beat_cnt == '0);
    assign rd_busy  = (state == RD_BURST) || (state == RD_DRAIN);

    // beat_cnt counts burst offsets, then reuses 0..1 for the two drain cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (state == RD_BURST) begin
            beat_cnt <= beat_cnt + OW'(1);
        end else if (state == RD_DRAIN) begin
            beat_cnt <= (beat_cnt == OW'(1)) ? '0 : beat_cnt + OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == WR) begin
            starve_cnt <= '0;
        end else if (wr_req && !starved) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_din  <= '0;
            page     <= '0;
        end else if (wr_win) begin
            ram_addr <= wr_addr;
            ram_din  <= wr_data;
        end else if (rd_win) begin
            ram_addr <= {rd_base[AW-1:OW], {OW{1'b0}}};
            page     <= rd_base[AW-1:OW];
        end else if (state == RD_BURST && beat_cnt != OW'(BURST - 1)) begin
            ram_addr <= {page, beat_cnt + OW'(1)};
        end
    end

    // Two-stage valid pipeline matches RAM read latency plus the rd_data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_v    <= 1'b0;
            dout_last <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
        end else begin
            dout_v    <= (state == RD_BURST);
            dout_last <= (state == RD_BURST) && (beat_cnt == OW'(BURST - 1));
            rd_valid  <= dout_v;
            rd_last   <= dout_last;
            if (dout_v) rd_data <= ram_dout;
        end
    end

endmodule

// File: tb/tb_lcd_ram_arbiter.sv
// Scoreboard bench for lcd_ram_arbiter: a behavioural RAM plus a shadow memory predict
// every write, grant and read beat with its cycle; a monitor pops and compares.
module tb_lcd_ram_arbiter;

    localparam int AW         = 6;
    localparam int DW         = 64;
    localparam int BURST      = 8;
    localparam int STARVE_MAX = 16;
    localparam int WORDS      = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_base = '0;
    logic          rd_grant, rd_busy, rd_valid, rd_last;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    lcd_ram_arbiter #(.AW(AW), .DW(DW), .BURST(BURST), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_base(rd_base), .rd_grant(rd_grant), .rd_busy(rd_busy),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram_mem [WORDS];
    logic [DW-1:0] ref_mem [WORDS];

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int c; } wr_exp_t;
    typedef struct { logic [DW-1:0] data; logic last; int c; } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    int      grant_q[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    wr_exp_t mw;
    rd_exp_t mr;
    int      mg;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_ack || ram_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {62'd0, wr_ack, ram_we}, 64'd0);
                end else begin
                    mw = wr_q.pop_front();
                    chk("wr_ack", wr_ack, 1);
                    chk("ram_we", ram_we, 1);
                    chk("ram_addr", ram_addr, mw.addr);
                    chk("ram_din", ram_din, mw.data);
                    chk("wr_ack_cycle", cyc, mw.c);
                end
            end
            if (rd_grant) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", rd_grant, 0);
                end else begin
                    mg = grant_q.pop_front();
                    chk("rd_grant_cycle", cyc, mg);
                    chk("rd_busy_at_grant", rd_busy, 1);
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    mr = rd_q.pop_front();
                    chk("rd_data", rd_data, mr.data);
                    chk("rd_last", rd_last, mr.last);
                    chk("rd_valid_cycle", cyc, mr.c);
                    chk("rd_busy_at_beat", rd_busy, 1);
                end
            end else if (rd_last) begin
                chk("rd_last_without_valid", rd_last, 0);
            end
        end
    end

    task automatic push_burst(input logic [AW-1:0] base, input int c);
        logic [AW-1:0] pg;
        pg = base & ~AW'(BURST - 1);
        grant_q.push_back(c + 1);
        for (int k = 0; k < BURST; k++)
            rd_q.push_back('{ref_mem[pg + AW'(k)], (k == BURST - 1), c + 3 + k});
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int c;
        c = cyc;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        wr_q.push_back('{a, d, c + 1});
        ref_mem[a] = d;
        @(negedge clk);
        wr_req = 1'b0; wr_addr = AW'($urandom); wr_data = {$urandom, $urandom};
        @(negedge clk);
    endtask

    task automatic do_read(input logic [AW-1:0] base);
        int c;
        c = cyc;
        rd_req = 1'b1; rd_base = base;
        push_burst(base, c);
        @(negedge clk);
        rd_req = 1'b0; rd_base = AW'($urandom);
        repeat (BURST + 2) @(negedge clk);
    endtask

    task automatic do_both(input logic [AW-1:0] base, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        int c;
        c = cyc;
        rd_req = 1'b1; rd_base = base;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        push_burst(base, c);
        wr_q.push_back('{a, d, c + BURST + 4});
        ref_mem[a] = d;
        @(negedge clk);
        rd_req = 1'b0;
        while (cyc < c + BURST + 4) @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    // Both requests held: bursts recur every BURST+3 cycles until the write has waited STARVE_MAX
    task automatic do_starve(input logic [AW-1:0] base, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        int c, t;
        c = cyc;
        t = c;
        rd_req = 1'b1; rd_base = base;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        while (t - c < STARVE_MAX) begin
            push_burst(base, t);
            t += BURST + 3;
        end
        wr_q.push_back('{a, d, t + 1});
        ref_mem[a] = d;
        push_burst(base, t + 2);
        while (cyc < t + 1) @(negedge clk);
        wr_req = 1'b0;
        while (cyc < t + 3) @(negedge clk);
        rd_req = 1'b0;
        while (cyc < t + BURST + 5) @(negedge clk);
    endtask

    task automatic reset_mid_burst(input logic [AW-1:0] base);
        rd_req = 1'b1; rd_base = base;
        push_burst(base, cyc);
        @(negedge clk);
        rd_req = 1'b0;
        repeat (4) @(negedge clk);
        wr_req = 1'b1; wr_addr = 6'd9; wr_data = {$urandom, $urandom};
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_rd_grant", rd_grant, 0);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_rd_data", rd_data, 0);
        rd_q.delete();
        grant_q.delete();
        repeat (3) @(negedge clk);
        wr_req = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        #12;
        chk("init_wr_ack", wr_ack, 0);
        chk("init_ram_we", ram_we, 0);
        chk("init_rd_valid", rd_valid, 0);
        chk("init_rd_busy", rd_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < WORDS; i++) do_write(AW'(i), DW'(i));
        do_read(6'd8);
        do_read(6'd13);
        do_read(6'd56);
        do_write(6'd5, 64'hA5A5_A5A5_A5A5_A5A5);
        do_read(6'd0);

        do_both(6'd16, 6'd20, 64'hDEAD_BEEF_0000_0014);
        do_read(6'd16);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0: do_write(AW'($urandom), {$urandom, $urandom});
                1: do_read(AW'($urandom));
                default: do_both(AW'($urandom), AW'($urandom), {$urandom, $urandom});
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        do_starve(6'd40, 6'd42, 64'h0123_4567_89AB_CDEF);
        do_starve(AW'($urandom), AW'($urandom), {$urandom, $urandom});

        reset_mid_burst(6'd24);
        do_read(6'd24);
        do_write(6'd63, 64'hFFFF_0000_FFFF_0000);
        do_read(6'd57);

        repeat (4) @(negedge clk);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("grant_queue_drained", grant_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
